// File: rtl/lab_prog_clk_div.sv
// Programmable clock-enable divider: registered div_clk, end-of-period tick, handshaked ratio update.
// Optional tick counter enabled by defining LAB_DIV_TICK_CNT_EN; otherwise tick_cnt is tied to 0.
module lab_prog_clk_div #(
  parameter int unsigned DIV_W     = 8,
  parameter int unsigned RST_RATIO = 2,
  parameter int unsigned TICK_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DIV_W-1:0]  cfg_ratio,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              div_clk,
  output logic              tick,
  output logic              busy,
  output logic [TICK_W-1:0] tick_cnt
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [DIV_W-1:0] RST_N = DIV_W'(RST_RATIO);
  localparam logic [DIV_W-1:0] ONE   = DIV_W'(1);
  localparam logic [DIV_W-1:0] TWO   = DIV_W'(2);

  state_t           state, state_nx;
  logic [DIV_W-1:0] cnt, cnt_nx;
  logic [DIV_W-1:0] n_act, n_act_nx;
  logic [DIV_W-1:0] n_pend, n_pend_nx;
  logic             pending, pending_nx;
  logic             div_clk_nx, tick_nx;
  logic [DIV_W-1:0] ratio_cl;
  logic [DIV_W:0]   half_nx;
  logic             boundary, xfer;

  // State register; div_clk/tick are registered from the next-state decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      n_act   <= RST_N;
      n_pend  <= '0;
      pending <= 1'b0;
      div_clk <= 1'b0;
      tick    <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      n_act   <= n_act_nx;
      n_pend  <= n_pend_nx;
      pending <= pending_nx;
      div_clk <= div_clk_nx;
      tick    <= tick_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    n_act_nx   = n_act;
    n_pend_nx  = n_pend;
    pending_nx = pending;
    ratio_cl   = (cfg_ratio < TWO) ? TWO : cfg_ratio;
    xfer       = cfg_valid && !pending;
    boundary   = (state == RUN) && (cnt == n_act - ONE);
    case (state)
      IDLE: begin
        if (xfer) n_act_nx = ratio_cl;
        if (en) begin
          state_nx = RUN;
          cnt_nx   = '0;
        end
      end
      RUN: begin
        if (boundary) begin
          if (pending) begin
            n_act_nx   = n_pend;
            pending_nx = 1'b0;
          end
          // A transfer on a stopping boundary has no later boundary to wait for.
          if (xfer) begin
            if (en) begin
              n_pend_nx  = ratio_cl;
              pending_nx = 1'b1;
            end else begin
              n_act_nx = ratio_cl;
            end
          end
          cnt_nx   = '0;
          state_nx = en ? RUN : IDLE;
        end else begin
          cnt_nx = cnt + ONE;
          if (xfer) begin
            n_pend_nx  = ratio_cl;
            pending_nx = 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    half_nx    = ({1'b0, n_act_nx} + (DIV_W+1)'(1)) >> 1;
    div_clk_nx = (state_nx == RUN) && ({1'b0, cnt_nx} < half_nx);
    tick_nx    = (state_nx == RUN) && (cnt_nx == n_act_nx - ONE);
  end

  assign busy      = (state == RUN);
  assign cfg_ready = !pending;

`ifdef LAB_DIV_TICK_CNT_EN
  logic [TICK_W-1:0] tick_cnt_q;

  always_ff @(posedge clk) begin
    if (rst)       tick_cnt_q <= '0;
    else if (tick) tick_cnt_q <= tick_cnt_q + TICK_W'(1);
  end

  assign tick_cnt = tick_cnt_q;
`else
  assign tick_cnt = '0;
`endif

endmodule
